capsense_scan_sequencer: RTL and testbench

Scan controller for the CapSense CSD measurement channel. It steps through a masked set of sensor pins. For each enabled sensor it drives the analog mux, waits a settle interval, runs one start/interrupt handshake with the measurement channel, and latches the raw count. Each result is handed out on a valid/ready port. It sits between the firmware-facing control registers and the measurement channel's `start`/`interrupt` pins.

---
 rtl/capsense_pkg.sv | 26 ++
 rtl/capsense_mask_seek.sv | 27 ++
 rtl/capsense_scan_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_capsense_scan_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/capsense_pkg.sv
// Shared types and helpers for the CapSense CSD scan sequencer.
// Holds the scan state encoding, the timeout count pattern and a width helper.
package capsense_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SEEK,
      SETTLE,
      MEASURE,
      RELEASE,
      PUSH,
      FINISH
   } state_t;

   // Raw count reported for a timed-out measurement, sliced to COUNT_W by users.
   localparam logic [63:0] TIMEOUT_COUNT = '1;

   function automatic int clog2(input int value);
      int result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/capsense_mask_seek.sv
// Combinational search for the lowest set mask bit at or above a start index.
// hit=0 means no enabled sensor remains in the scan.
module capsense_mask_seek
   import capsense_pkg::*;
#(
   parameter  int NUM_SENSORS = 16,
   localparam int SEL_W       = clog2(NUM_SENSORS)
) (
   input  logic [NUM_SENSORS-1:0] mask,
   input  logic [SEL_W-1:0]       idx,
   output logic [SEL_W-1:0]       found,
   output logic                   hit
);

   // Walking from the top down lets the lowest qualifying bit win.
   always_comb begin
      found = '0;
      hit   = 1'b0;
      for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
         if (mask[i] && (i >= int'(idx))) begin
            found = SEL_W'(i);
            hit   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/capsense_scan_sequencer.sv
// Steps through the masked sensors: mux select, settle, start/interrupt handshake
// with the CSD channel, then hands each raw count out on a valid/ready port.
module capsense_scan_sequencer
   import capsense_pkg::*;
#(
   parameter  int NUM_SENSORS    = 16,
   parameter  int COUNT_W        = 16,
   parameter  int SETTLE_CYCLES  = 8,
   parameter  int TIMEOUT_CYCLES = 4096,
   localparam int SEL_W          = clog2(NUM_SENSORS)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   scan_req,
   input  logic                   continuous,
   input  logic                   abort,
   input  logic [NUM_SENSORS-1:0] sensor_mask,
   output logic [SEL_W-1:0]       mux_sel,
   output logic                   mux_en,
   output logic                   meas_start,
   input  logic                   meas_done,
   input  logic [COUNT_W-1:0]     meas_count,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [SEL_W-1:0]       res_sensor,
   output logic [COUNT_W-1:0]     res_count,
   output logic                   res_timeout,
   output logic                   busy,
   output logic                   scan_done
);

   localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
   localparam logic [15:0]      TMO_LOAD    = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [SEL_W-1:0] LAST_SEL    = SEL_W'(NUM_SENSORS - 1);

   state_t                 state_q, state_d;
   logic [NUM_SENSORS-1:0] mask_q, mask_d;
   logic [SEL_W-1:0]       idx_q, idx_d;
   logic                   abort_q, abort_d;
   logic [7:0]             settle_q, settle_d;
   logic [15:0]            tmo_q, tmo_d;
   logic [SEL_W-1:0]       mux_sel_d, res_sensor_d, found;
   logic [COUNT_W-1:0]     res_count_d;
   logic                   mux_en_d, meas_start_d, res_valid_d, res_timeout_d, hit;

   capsense_mask_seek #(.NUM_SENSORS(NUM_SENSORS)) u_seek (
      .mask  (mask_q),
      .idx   (idx_q),
      .found (found),
      .hit   (hit)
   );

   always_comb begin
      // NOTE: every signal assigned here gets a hold default first, so no latch is inferred.
      state_d       = state_q;
      mask_d        = mask_q;
      idx_d         = idx_q;
      abort_d       = abort_q;
      settle_d      = settle_q;
      tmo_d         = tmo_q;
      mux_sel_d     = mux_sel;
      mux_en_d      = mux_en;
      meas_start_d  = meas_start;
      res_valid_d   = res_valid;
      res_sensor_d  = res_sensor;
      res_count_d   = res_count;
      res_timeout_d = res_timeout;
      unique case (state_q)
         IDLE: if (scan_req) begin
            mask_d  = sensor_mask;
            idx_d   = '0;
            abort_d = 1'b0;
            state_d = SEEK;
         end
         SEEK: if (abort) begin
            abort_d = 1'b1;
            state_d = RELEASE;
         end else if (hit) begin
            mux_sel_d = found;
            mux_en_d  = 1'b1;
            settle_d  = SETTLE_LOAD;
            state_d   = SETTLE;
         end else begin
            state_d = FINISH;
         end
         SETTLE: if (abort) begin
            abort_d = 1'b1;
            state_d = RELEASE;
         end else if (settle_q == 8'd0) begin
            meas_start_d = 1'b1;
            tmo_d        = TMO_LOAD;
            state_d      = MEASURE;
         end else begin
            settle_d = settle_q - 8'd1;
         end
         MEASURE: if (abort) begin
            abort_d      = 1'b1;
            meas_start_d = 1'b0;
            state_d      = RELEASE;
         end else if (meas_done || tmo_q == 16'd0) begin
            res_sensor_d  = mux_sel;
            res_count_d   = meas_done ? meas_count : TIMEOUT_COUNT[COUNT_W-1:0];
            res_timeout_d = !meas_done;
            meas_start_d  = 1'b0;
            state_d       = RELEASE;
         end else begin
            tmo_d = tmo_q - 16'd1;
         end
         // A timed-out channel may never drop its interrupt, so do not wait on it.
         RELEASE: if (abort_q) begin
            if (!meas_done) begin
               mux_en_d = 1'b0;
               state_d  = FINISH;
            end
         end else if (res_timeout || !meas_done) begin
            res_valid_d = 1'b1;
            state_d     = PUSH;
         end
         PUSH: begin
            abort_d = abort_q | abort;
            if (res_ready) begin
               res_valid_d = 1'b0;
               mux_en_d    = 1'b0;
               if (abort || abort_q || mux_sel == LAST_SEL) begin
                  state_d = FINISH;
               end else begin
                  idx_d   = mux_sel + 1'b1;
                  state_d = SEEK;
               end
            end
         end
         FINISH: begin
            abort_d = 1'b0;
            if (continuous && !abort && !abort_q) begin
               mask_d  = sensor_mask;
               idx_d   = '0;
               state_d = SEEK;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      if (!reset) begin
         state_q     <= IDLE;
         mask_q      <= '0;
         idx_q       <= '0;
         abort_q     <= 1'b0;
         settle_q    <= '0;
         tmo_q       <= '0;
         mux_sel     <= '0;
         mux_en      <= 1'b0;
         meas_start  <= 1'b0;
         res_valid   <= 1'b0;
         res_sensor  <= '0;
         res_count   <= '0;
         res_timeout <= 1'b0;
         busy        <= 1'b0;
         scan_done   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         idx_q       <= idx_d;
         abort_q     <= abort_d;
         settle_q    <= settle_d;
         tmo_q       <= tmo_d;
         mux_sel     <= mux_sel_d;
         mux_en      <= mux_en_d;
         meas_start  <= meas_start_d;
         res_valid   <= res_valid_d;
         res_sensor  <= res_sensor_d;
         res_count   <= res_count_d;
         res_timeout <= res_timeout_d;
         busy        <= (state_d != IDLE);
         scan_done   <= (state_d == FINISH);
      end
   end

endmodule

// File: tb/tb_capsense_scan_sequencer.sv
// Directed bench for the scan sequencer: a default instance for the main flows
// and a short-timeout instance whose channel never answers.
module tb_capsense_scan_sequencer;

   logic        clock, reset;
   logic        scan_req, continuous, abort, meas_done, res_ready;
   logic [15:0] sensor_mask, meas_count;
   logic [3:0]  mux_sel, res_sensor;
   logic        mux_en, meas_start, res_valid, res_timeout, busy, scan_done;
   logic [15:0] res_count;

   logic        t_scan_req, t_res_ready;
   logic [15:0] t_mask, t_res_count;
   logic [3:0]  t_mux_sel, t_res_sensor;
   logic        t_mux_en, t_meas_start, t_res_valid, t_res_timeout, t_busy, t_scan_done;
   logic        t_low;
   logic [15:0] t_zero;

   int tests  = 0;
   int failed = 0;

   capsense_scan_sequencer dut (
      .clock(clock), .reset(reset), .scan_req(scan_req), .continuous(continuous),
      .abort(abort), .sensor_mask(sensor_mask), .mux_sel(mux_sel), .mux_en(mux_en),
      .meas_start(meas_start), .meas_done(meas_done), .meas_count(meas_count),
      .res_valid(res_valid), .res_ready(res_ready), .res_sensor(res_sensor),
      .res_count(res_count), .res_timeout(res_timeout), .busy(busy), .scan_done(scan_done)
   );

   capsense_scan_sequencer #(.TIMEOUT_CYCLES(16)) dut_tmo (
      .clock(clock), .reset(reset), .scan_req(t_scan_req), .continuous(t_low),
      .abort(t_low), .sensor_mask(t_mask), .mux_sel(t_mux_sel), .mux_en(t_mux_en),
      .meas_start(t_meas_start), .meas_done(t_low), .meas_count(t_zero),
      .res_valid(t_res_valid), .res_ready(t_res_ready), .res_sensor(t_res_sensor),
      .res_count(t_res_count), .res_timeout(t_res_timeout), .busy(t_busy), .scan_done(t_scan_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests++;
      assert (observed === expected) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Waits for meas_start, answers after dly cycles with cnt, checks the result payload.
   task automatic run_meas(input logic [15:0] cnt, input int dly, input logic [3:0] sen);
      for (int i = 0; i < 64 && meas_start !== 1'b1; i++) step();
      check("meas_start_seen", meas_start, 1);
      repeat (dly) step();
      check("no_early_timeout", meas_start, 1);
      meas_done  = 1'b1;
      meas_count = cnt;
      step();
      check("start_drop_1cyc", meas_start, 0);
      check("valid_waits_done_low", res_valid, 0);
      meas_done  = 1'b0;
      meas_count = 16'h0000;
      step();
      check("res_valid", res_valid, 1);
      check("res_sensor", res_sensor, sen);
      check("res_count", res_count, cnt);
      check("res_timeout", res_timeout, 0);
   endtask

   initial begin
      reset = 1'b1; scan_req = 1'b0; continuous = 1'b0; abort = 1'b0;
      meas_done = 1'b0; res_ready = 1'b0; sensor_mask = '0; meas_count = '0;
      t_scan_req = 1'b0; t_res_ready = 1'b0; t_mask = '0; t_low = 1'b0; t_zero = '0;
      #2 reset = 1'b0;
      #10;
      check("rst_outputs", {mux_sel, mux_en, meas_start, res_valid, res_sensor, res_timeout, busy, scan_done}, 0);
      check("rst_res_count", res_count, 0);
      step();
      reset = 1'b1;
      step();

      // Mask 0x0005: sensors 0 and 2, with a 10-cycle result stall on sensor 0.
      sensor_mask = 16'h0005; scan_req = 1'b1;
      step();
      scan_req = 1'b0;
      check("busy_after_req", busy, 1);
      check("mux_en_seek", mux_en, 0);
      step();
      check("mux_en_2cyc", mux_en, 1);
      check("mux_sel_s0", mux_sel, 0);
      repeat (7) step();
      check("settle_not_yet", meas_start, 0);
      step();
      check("settle_8cyc", meas_start, 1);
      run_meas(16'h1234, 20, 4'd0);
      for (int i = 0; i < 10; i++) begin
         step();
         check("stall_hold", {res_valid, meas_start, mux_sel, res_sensor, res_count},
               {1'b1, 1'b0, 4'd0, 4'd0, 16'h1234});
      end
      res_ready = 1'b1;
      step();
      check("hs_valid_low", res_valid, 0);
      check("hs_mux_off", mux_en, 0);
      step();
      check("next_mux_en_2cyc", mux_en, 1);
      check("next_mux_sel", mux_sel, 2);
      run_meas(16'h0ABC, 20, 4'd2);
      step();
      check("no_done_in_seek", scan_done, 0);
      step();
      check("scan_done_pulse", scan_done, 1);
      check("mux_off_finish", mux_en, 0);
      step();
      check("done_one_cycle", {scan_done, busy}, 0);

      // Empty mask: straight to FINISH, no results.
      res_ready = 1'b0; sensor_mask = 16'h0000; scan_req = 1'b1;
      step();
      scan_req = 1'b0;
      check("empty_seek", {scan_done, mux_en, res_valid}, 0);
      step();
      check("empty_done_2cyc", {scan_done, mux_en, res_valid}, 3'b100);
      step();
      check("empty_idle", busy, 0);

      // Short-timeout instance, channel silent, mask 0x0003.
      t_mask = 16'h0003; t_scan_req = 1'b1;
      step();
      t_scan_req = 1'b0;
      for (int i = 0; i < 64 && t_meas_start !== 1'b1; i++) step();
      check("tmo_start_seen", t_meas_start, 1);
      repeat (15) step();
      check("tmo_still_waiting", t_meas_start, 1);
      step();
      check("tmo_start_dropped", t_meas_start, 0);
      check("tmo_valid_not_yet", t_res_valid, 0);
      step();
      check("tmo_res_valid", t_res_valid, 1);
      check("tmo_res_count", t_res_count, 16'hFFFF);
      check("tmo_res_flag", t_res_timeout, 1);
      check("tmo_res_sensor", t_res_sensor, 0);
      t_res_ready = 1'b1;
      step();
      step();
      check("tmo_continues", {t_mux_en, t_mux_sel, t_meas_start}, {1'b1, 4'd1, 1'b0});

      // Abort during SETTLE of sensor 1, mask 0x0003.
      res_ready = 1'b1; sensor_mask = 16'h0003; scan_req = 1'b1;
      step();
      scan_req = 1'b0;
      run_meas(16'h0011, 3, 4'd0);
      step();
      step();
      check("abort_settle_s1", {mux_en, mux_sel}, {1'b1, 4'd1});
      abort = 1'b1;
      step();
      check("abort_release", {meas_start, res_valid, scan_done}, 0);
      step();
      abort = 1'b0;
      check("abort_finish", {scan_done, mux_en, res_valid}, 3'b100);
      step();
      check("abort_idle", {busy, scan_done}, 0);

      // Continuous scanning of sensor 3, then reset in the middle of MEASURE.
      continuous = 1'b1; sensor_mask = 16'h0008; scan_req = 1'b1;
      step();
      scan_req = 1'b0;
      run_meas(16'h0333, 2, 4'd3);
      step();
      step();
      check("cont_done_pulse", {scan_done, busy}, 2'b11);
      step();
      check("cont_restart", {scan_done, busy}, 2'b01);
      run_meas(16'h0444, 5, 4'd3);
      for (int i = 0; i < 64 && meas_start !== 1'b1; i++) step();
      check("cont_third_start", meas_start, 1);
      repeat (3) step();
      #2 reset = 1'b0;
      #1;
      check("async_rst_outputs", {mux_sel, mux_en, meas_start, res_valid, res_sensor, res_timeout, busy, scan_done}, 0);
      check("async_rst_count", res_count, 0);
      check("async_rst_tmo_inst", {t_busy, t_scan_done, t_res_valid}, 0);
      continuous = 1'b0;
      step();
      reset = 1'b1;
      step();
      step();
      check("post_rst_idle", {busy, scan_done, mux_en}, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
